// File: rtl/rst_seq_fpga.sv
// Purpose: synchronise/debounce the raw reset sources, wait for a stable lock window, then release core and peripheral resets in order.
// Latency: async pin to reset assertion is 2 sync edges + 1 (plus DebounceCycles for the pushbutton); release follows the lock/stage timers.
// Backpressure: none; outputs are level reset signals. Optional cause/count outputs are enabled by RST_SEQ_CAUSE_EN.
module rst_seq_fpga #(
    parameter int LockStableCycles = 1024,
    parameter int DebounceCycles   = 16,
    parameter int StageGap         = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       ext_rst_ni,
    input  logic       jtag_srst_ni,
    input  logic       sw_rst_req_i,
    output logic       rst_core_no,
    output logic       rst_periph_no,
    output logic       rst_done_o
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [3:0] rst_cause_o,
    output logic [7:0] rst_count_o
`endif
);

    localparam int LOCK_W = $clog2(LockStableCycles + 1);
    localparam int DEB_W  = $clog2(DebounceCycles + 1);
    localparam int GAP_W  = $clog2(StageGap + 1);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_LOCK  = 3'd1,
        REL_CORE   = 3'd2,
        REL_PERIPH = 3'd3,
        RUN        = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [DEB_W-1:0]  deb_cnt;

    logic pll_meta, pll_sync;
    logic ext_meta, ext_sync;
    logic jtag_meta, jtag_sync;
    logic deb_ext;

    logic good;
    logic fault;
    logic hold_entry;

    // Two-flop synchronisers for the three asynchronous sources; reset to 0 so sources start "bad".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pll_meta  <= 1'b0;
            pll_sync  <= 1'b0;
            ext_meta  <= 1'b0;
            ext_sync  <= 1'b0;
            jtag_meta <= 1'b0;
            jtag_sync <= 1'b0;
        end else begin
            pll_meta  <= pll_locked_i;
            pll_sync  <= pll_meta;
            ext_meta  <= ext_rst_ni;
            ext_sync  <= ext_meta;
            jtag_meta <= jtag_srst_ni;
            jtag_sync <= jtag_meta;
        end
    end

    // Pushbutton debounce: accept a new level only after DebounceCycles consecutive disagreeing cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_ext <= 1'b0;
            deb_cnt <= '0;
        end else if (ext_sync != deb_ext) begin
            if (deb_cnt == DEB_W'(DebounceCycles - 1)) begin
                deb_ext <= ext_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign good  = pll_sync & deb_ext & jtag_sync;
    assign fault = ~good | sw_rst_req_i;

    // Next-state and counter logic; a fault in any released state wins over a same-cycle stage advance.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        gap_cnt_nxt  = gap_cnt;
        hold_entry   = 1'b0;
        case (state)
            HOLD: begin
                lock_cnt_nxt = '0;
                if (fault) begin
                    gap_cnt_nxt = '0;
                end else if (gap_cnt == GAP_W'(StageGap - 1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = WAIT_LOCK;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                gap_cnt_nxt = '0;
                if (!good) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_W'(LockStableCycles - 1)) begin
                    lock_cnt_nxt = '0;
                    state_nxt    = REL_CORE;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            REL_CORE: begin
                if (fault) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = HOLD;
                    hold_entry  = 1'b1;
                end else if (gap_cnt == GAP_W'(StageGap - 1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = REL_PERIPH;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            REL_PERIPH: begin
                gap_cnt_nxt = '0;
                hold_entry  = fault;
                state_nxt   = fault ? HOLD : RUN;
            end
            RUN: begin
                gap_cnt_nxt = '0;
                if (fault) begin
                    state_nxt  = HOLD;
                    hold_entry = 1'b1;
                end
            end
            default: begin
                state_nxt    = HOLD;
                gap_cnt_nxt  = '0;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // State, counters and registered decode of the next state onto the reset outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= HOLD;
            lock_cnt      <= '0;
            gap_cnt       <= '0;
            rst_core_no   <= 1'b0;
            rst_periph_no <= 1'b0;
            rst_done_o    <= 1'b0;
        end else begin
            state         <= state_nxt;
            lock_cnt      <= lock_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            rst_core_no   <= (state_nxt == REL_CORE) || (state_nxt == REL_PERIPH) || (state_nxt == RUN);
            rst_periph_no <= (state_nxt == REL_PERIPH) || (state_nxt == RUN);
            rst_done_o    <= (state_nxt == RUN);
        end
    end

`ifdef RST_SEQ_CAUSE_EN
    // Latch the fault terms on each fall-back into HOLD and count such events, saturating at 255.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cause_o <= 4'b0000;
            rst_count_o <= 8'h00;
        end else if (hold_entry) begin
            rst_cause_o <= {sw_rst_req_i, ~jtag_sync, ~deb_ext, ~pll_sync};
            if (rst_count_o != 8'hFF) begin
                rst_count_o <= rst_count_o + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rst_seq_fpga.sv
// Purpose: scoreboard bench for rst_seq_fpga; expected output transitions are queued with their cycle as stimulus is driven.
// Latency: every output change is matched against the head of the queue for both cycle number and value.
// Backpressure: not applicable; optional cause/count checks are compiled in with RST_SEQ_CAUSE_EN.
module tb_rst_seq_fpga;

    logic clk_i;
    logic rst_i;
    logic pll_locked_i;
    logic ext_rst_ni;
    logic jtag_srst_ni;
    logic sw_rst_req_i;
    logic rst_core_no;
    logic rst_periph_no;
    logic rst_done_o;
`ifdef RST_SEQ_CAUSE_EN
    logic [3:0] rst_cause_o;
    logic [7:0] rst_count_o;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  outs;   // {core_n, periph_n, done}
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_fail;
    logic        mon_en;

    rst_seq_fpga #(
        .LockStableCycles(16),
        .DebounceCycles  (4),
        .StageGap        (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pll_locked_i (pll_locked_i),
        .ext_rst_ni   (ext_rst_ni),
        .jtag_srst_ni (jtag_srst_ni),
        .sw_rst_req_i (sw_rst_req_i),
        .rst_core_no  (rst_core_no),
        .rst_periph_no(rst_periph_no),
        .rst_done_o   (rst_done_o)
`ifdef RST_SEQ_CAUSE_EN
        ,
        .rst_cause_o  (rst_cause_o),
        .rst_count_o  (rst_count_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // cyc = number of rising edges seen so far
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic expect_edge(input int unsigned c, input logic [2:0] o);
        exp_t e;
        e.cyc  = c;
        e.outs = o;
        sb.push_back(e);
    endtask

    task automatic to_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk_i);
    endtask

    // Monitor: on every observed output change, pop the next expected transition and compare.
    initial begin
        logic [2:0] prev;
        logic [2:0] cur;
        exp_t       e;
        prev = 3'b000;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                cur = {rst_core_no, rst_periph_no, rst_done_o};
                if (cur !== prev) begin
                    if (sb.size() == 0) begin
                        chk_eq("unexpected_change", {29'b0, cur}, {29'b0, prev});
                    end else begin
                        e = sb.pop_front();
                        chk_eq("edge_cycle", cyc, e.cyc);
                        chk_eq("edge_value", {29'b0, cur}, {29'b0, e.outs});
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int unsigned t;
        int unsigned r;
        int unsigned e;
        n_chk        = 0;
        n_fail       = 0;
        mon_en       = 1'b0;
        rst_i        = 1'b1;
        pll_locked_i = 1'b1;
        ext_rst_ni   = 1'b1;
        jtag_srst_ni = 1'b1;
        sw_rst_req_i = 1'b0;

        // 1. Power-up reset for two edges, all sources good from time 0.
        to_cyc(2);
        chk_eq("reset_outputs", {29'b0, rst_core_no, rst_periph_no, rst_done_o}, 32'd0);
`ifdef RST_SEQ_CAUSE_EN
        chk_eq("reset_cause", {28'b0, rst_cause_o}, 32'd0);
        chk_eq("reset_count", {24'b0, rst_count_o}, 32'd0);
`endif
        mon_en = 1'b1;
        rst_i  = 1'b0;
        r = cyc;
        // sync 2 + debounce 4 -> good from cycle r+6; HOLD 3 -> WAIT_LOCK at r+9; +16 -> core r+25
        expect_edge(r + 25, 3'b100);
        expect_edge(r + 28, 3'b110);
        expect_edge(r + 29, 3'b111);
        to_cyc(r + 35);

        // 3. Pushbutton low 3 cycles in RUN: shorter than the debounce window, no change.
        t = cyc;
        ext_rst_ni = 1'b0;
        to_cyc(t + 3);
        ext_rst_ni = 1'b1;
        to_cyc(t + 12);

        // 4. Pushbutton low 4 cycles: deb_ext falls at t+6, resets drop at t+7; re-debounce high at t+10.
        t = cyc;
        ext_rst_ni = 1'b0;
        expect_edge(t + 7, 3'b000);
        expect_edge(t + 29, 3'b100);
        expect_edge(t + 32, 3'b110);
        expect_edge(t + 33, 3'b111);
        to_cyc(t + 4);
        ext_rst_ni = 1'b1;
        to_cyc(t + 8);
`ifdef RST_SEQ_CAUSE_EN
        chk_eq("cause_ext", {28'b0, rst_cause_o}, 32'h2);
        chk_eq("count_ext", {24'b0, rst_count_o}, 32'd1);
`endif
        to_cyc(t + 40);

        // 5. Single-cycle software request in RUN: resets drop next edge, full re-sequence.
        t = cyc;
        sw_rst_req_i = 1'b1;
        expect_edge(t + 1, 3'b000);
        expect_edge(t + 20, 3'b100);
        expect_edge(t + 23, 3'b110);
        expect_edge(t + 24, 3'b111);
        to_cyc(t + 1);
        sw_rst_req_i = 1'b0;
        to_cyc(t + 2);
`ifdef RST_SEQ_CAUSE_EN
        chk_eq("cause_sw", {28'b0, rst_cause_o}, 32'h8);
        chk_eq("count_sw", {24'b0, rst_count_o}, 32'd2);
`endif
        to_cyc(t + 30);

        // 6. JTAG reset synced low exactly in the cycle the REL_CORE gap expires -> HOLD, not REL_PERIPH.
        t = cyc;
        e = t + 20;
        sw_rst_req_i = 1'b1;
        expect_edge(t + 1, 3'b000);
        expect_edge(e, 3'b100);
        expect_edge(e + 3, 3'b000);
        expect_edge(e + 22, 3'b100);
        expect_edge(e + 25, 3'b110);
        expect_edge(e + 26, 3'b111);
        to_cyc(t + 1);
        sw_rst_req_i = 1'b0;
        to_cyc(e);
        jtag_srst_ni = 1'b0;
        to_cyc(e + 1);
        jtag_srst_ni = 1'b1;
        to_cyc(e + 4);
`ifdef RST_SEQ_CAUSE_EN
        chk_eq("cause_jtag", {28'b0, rst_cause_o}, 32'h4);
        chk_eq("count_jtag", {24'b0, rst_count_o}, 32'd4);
`endif
        to_cyc(e + 32);

        // 7. rst_i mid-RUN: outputs (and cause/count) zero on the next edge.
        t = cyc;
        rst_i = 1'b1;
        expect_edge(t + 1, 3'b000);
        to_cyc(t + 1);
`ifdef RST_SEQ_CAUSE_EN
        chk_eq("cause_rst", {28'b0, rst_cause_o}, 32'd0);
        chk_eq("count_rst", {24'b0, rst_count_o}, 32'd0);
`endif
        to_cyc(t + 2);
        rst_i = 1'b0;
        r = cyc;

        // 2. WAIT_LOCK entered r+9; lock_cnt=10 in cycle r+19, synced lock low r+19..r+23,
        //    lock returns in cycle r+24 -> core r+40.
        expect_edge(r + 40, 3'b100);
        expect_edge(r + 43, 3'b110);
        expect_edge(r + 44, 3'b111);
        to_cyc(r + 17);
        pll_locked_i = 1'b0;
        to_cyc(r + 22);
        pll_locked_i = 1'b1;
        to_cyc(r + 50);

        chk_eq("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
